m3_dequant: RTL and testbench
=============================

# m3_dequant

Dequantization and de-zigzag stage that sits directly upstream of the IDCT milestone. It accepts decoded DCT coefficients in zigzag order over a valid/ready stream, one 8x8 block at a time. It scales each coefficient by the selected power-of-two quantization matrix and writes the result, one 16-bit word per accepted coefficient, into the pre-IDCT SRAM segment in raster layout. The IDCT stage fetches from that segment.

## Interface
- BASE_ADDR, 18'd76800: SRAM word address of pre-IDCT segment pixel (0,0)
- NUM_BLOCKS_X, 40: blocks per row; row stride = NUM_BLOCKS_X*8 words
- NUM_BLOCKS_Y, 30: block rows
- CLOCK_50_I  in  1: system clock
- reset  in  1: synchronous, active-high
- m3_start  in  1: one-cycle start pulse; ignored unless in S_IDLE
- q_sel  in  1: quantization matrix select (0=Q0, 1=Q1); sampled on m3_start
- coeff_data  in  16: signed coefficient, zigzag order
- coeff_valid  in  1: coeff_data valid
- coeff_ready  out  1: stage accepts; transfer when valid&ready
- SRAM_address  out  18: write address
- SRAM_write_data  out  16: dequantized value
- SRAM_we_n  out  1: active-low write enable
- m3_end  out  1: one-cycle done pulse

## Operation
- States: S_IDLE, S_RUN, S_FLUSH, S_DONE.
- S_IDLE -> S_RUN on m3_start:
  - latch q_sel
  - clear k (0..63), block column bx and block row by
- S_RUN:
  - coeff_ready=1 in S_RUN only.
  - Each transfer: (r,c)=ZZ[k]; shift s=QSHIFT(q_sel,r+c).
  - Value = coeff_data <<< s, computed at 24 bits, then saturated to [-32768,32767].
  - Address = BASE_ADDR + (by*8+r)*(NUM_BLOCKS_X*8) + bx*8 + c, truncated to 18 bits.
  - k increments. On k=63: k->0 and bx increments. At bx=NUM_BLOCKS_X-1, bx->0 and by increments.
- Transfer of last coefficient (k=63, bx, by at max) -> S_FLUSH -> S_DONE.
- S_DONE: m3_end=1 for one cycle, -> S_IDLE.
- QSHIFT, Q0 by r+c: 0:3, 1:2, 2-3:3, 4-5:4, 6-7:5, >=8:6.
- QSHIFT, Q1 by r+c: 0:3, 1-3:1, 4-5:2, 6-7:3, 8-9:4, >=10:5.
- coeff_valid while not in S_RUN: not accepted, no effect.
- m3_start outside S_IDLE: ignored.
- Reset, including mid-block: state S_IDLE, counters 0, no partial writes retained or completed.

## Timing
- Reset values:
  - coeff_ready=0, SRAM_we_n=1
  - SRAM_address=0, SRAM_write_data=0
  - m3_end=0
- m3_start at cycle t -> coeff_ready=1 from t+1.
- Transfer at cycle t -> registered SRAM_address, SRAM_write_data, SRAM_we_n=0 during t+1.
- No transfer at t -> SRAM_we_n=1 at t+1; address and data hold.
- Throughput one coefficient per cycle; no internal bubbles.
- Last transfer at t:
  - coeff_ready=0 from t+1
  - last write in t+1 (S_FLUSH)
  - m3_end=1 in t+2
  - S_IDLE at t+3

## Structure
- Shared package `m3_pkg`:
  - state enum m3_state_type
  - 64-entry ZZ table (6-bit index -> {row[2:0],col[2:0]})
  - QSHIFT function
  - segment-base constant
- One sub-module: `m3_zigzag_rom` (combinational k -> {r,c}).
- Saturating shift and address arithmetic stay in m3_dequant.

## Test plan
- q_sel=0, block (0,0):
  - k=0 coeff 5 -> write 16'd40 @ BASE_ADDR
  - k=1 coeff -3 -> 16'hFFF4 @ BASE_ADDR+1
  - k=2 coeff 7 -> 16'd28 @ BASE_ADDR+320
- q_sel=1, k=63 (7,7), coeff 1000, s=5 -> 32000 @ BASE_ADDR+7*320+7. Same with coeff 2000 -> saturates to 32767. Coeff -2000 -> -32768.
- Block boundary: NUM_BLOCKS_X=2, NUM_BLOCKS_Y=1, 128 coefficients.
  - Second block's k=0 writes BASE_ADDR+8.
  - Exactly 128 writes.
  - m3_end one cycle after final write; coeff_ready=0 afterwards.
- Backpressure/gaps: random coeff_valid deassertion.
  - SRAM_we_n=0 only the cycle after each transfer.
  - Write order matches ZZ.
  - Coefficient count unchanged.
- Reset asserted at k=30 of block 0, then new m3_start:
  - SRAM_we_n=1 the cycle after reset.
  - Restart writes k=0 @ BASE_ADDR.
  - No m3_end before the full image is done.
- m3_start pulsed during S_RUN and coeff_valid in S_IDLE: no effect on counters, q_sel, or writes.

Source files
------------

// File: rtl/m3_pkg.sv
// Shared types, constants, zigzag table and quantization shift lookup for m3_dequant.
package m3_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } m3_state_type;

  localparam int unsigned M3_K_W     = 6;
  localparam int unsigned M3_RC_W    = 3;
  localparam int unsigned M3_SUM_W   = 4;
  localparam int unsigned M3_SHIFT_W = 3;
  localparam int unsigned M3_COEFF_W = 16;
  localparam int unsigned M3_WIDE_W  = 24;
  localparam int unsigned M3_ADDR_W  = 18;

  // Word address of pre-IDCT segment pixel (0,0)
  localparam logic [M3_ADDR_W-1:0] M3_SEG_BASE = 18'd76800;

  // Zigzag index -> {row,col}; each octal digit is one 3-bit coordinate
  localparam logic [2*M3_RC_W-1:0] M3_ZZ_TABLE [64] = '{
    6'o00, 6'o01, 6'o10, 6'o20, 6'o11, 6'o02, 6'o03, 6'o12,
    6'o21, 6'o30, 6'o40, 6'o31, 6'o22, 6'o13, 6'o04, 6'o05,
    6'o14, 6'o23, 6'o32, 6'o41, 6'o50, 6'o60, 6'o51, 6'o42,
    6'o33, 6'o24, 6'o15, 6'o06, 6'o07, 6'o16, 6'o25, 6'o34,
    6'o43, 6'o52, 6'o61, 6'o70, 6'o71, 6'o62, 6'o53, 6'o44,
    6'o35, 6'o26, 6'o17, 6'o27, 6'o36, 6'o45, 6'o54, 6'o63,
    6'o72, 6'o73, 6'o64, 6'o55, 6'o46, 6'o37, 6'o47, 6'o56,
    6'o65, 6'o74, 6'o75, 6'o66, 6'o57, 6'o67, 6'o76, 6'o77
  };

  // Power-of-two quantizer exponent, indexed by matrix select and diagonal r+c
  function automatic logic [M3_SHIFT_W-1:0] m3_qshift(input logic q,
                                                      input logic [M3_SUM_W-1:0] d);
    logic [M3_SHIFT_W-1:0] s;
    if (!q) begin
      if (d == 4'd0)       s = 3'd3;
      else if (d == 4'd1)  s = 3'd2;
      else if (d <= 4'd3)  s = 3'd3;
      else if (d <= 4'd5)  s = 3'd4;
      else if (d <= 4'd7)  s = 3'd5;
      else                 s = 3'd6;
    end else begin
      if (d == 4'd0)       s = 3'd3;
      else if (d <= 4'd3)  s = 3'd1;
      else if (d <= 4'd5)  s = 3'd2;
      else if (d <= 4'd7)  s = 3'd3;
      else if (d <= 4'd9)  s = 3'd4;
      else                 s = 3'd5;
    end
    return s;
  endfunction

endpackage

// File: rtl/m3_zigzag_rom.sv
// Combinational zigzag lookup: coefficient index k -> raster (row, col).
module m3_zigzag_rom
  import m3_pkg::*;
(
  input  logic [M3_K_W-1:0]  k_i,
  output logic [M3_RC_W-1:0] row_c_o,
  output logic [M3_RC_W-1:0] col_c_o
);

  logic [2*M3_RC_W-1:0] entry;

  // Table read and split into coordinates
  always_comb begin
    entry   = M3_ZZ_TABLE[k_i];
    row_c_o = entry[2*M3_RC_W-1:M3_RC_W];
    col_c_o = entry[M3_RC_W-1:0];
  end

endmodule

// File: rtl/m3_dequant.sv
// Dequantize zigzag-ordered coefficients by a power-of-two matrix and write
// them in raster order into the pre-IDCT SRAM segment.
module m3_dequant
  import m3_pkg::*;
#(
  parameter logic [M3_ADDR_W-1:0] BASE_ADDR    = M3_SEG_BASE,
  parameter int unsigned          NUM_BLOCKS_X = 40,
  parameter int unsigned          NUM_BLOCKS_Y = 30
) (
  input  logic                  CLOCK_50_I,
  input  logic                  reset,
  input  logic                  m3_start,
  input  logic                  q_sel,
  input  logic [M3_COEFF_W-1:0] coeff_data,
  input  logic                  coeff_valid,
  output logic                  coeff_ready,
  output logic [M3_ADDR_W-1:0]  SRAM_address,
  output logic [M3_COEFF_W-1:0] SRAM_write_data,
  output logic                  SRAM_we_n,
  output logic                  m3_end
);

  localparam int unsigned BX_W       = (NUM_BLOCKS_X > 1) ? $clog2(NUM_BLOCKS_X) : 1;
  localparam int unsigned BY_W       = (NUM_BLOCKS_Y > 1) ? $clog2(NUM_BLOCKS_Y) : 1;
  localparam int unsigned ROW_STRIDE = NUM_BLOCKS_X * 8;

  localparam logic [BX_W-1:0]   BX_LAST = BX_W'(NUM_BLOCKS_X - 1);
  localparam logic [BY_W-1:0]   BY_LAST = BY_W'(NUM_BLOCKS_Y - 1);
  localparam logic [M3_K_W-1:0] K_LAST  = 6'd63;

  localparam logic signed [M3_WIDE_W-1:0] SAT_HI = 24'sd32767;
  localparam logic signed [M3_WIDE_W-1:0] SAT_LO = -24'sd32768;

  m3_state_type state_q, state_d;
  logic [M3_K_W-1:0]     k_q, k_d;
  logic [BX_W-1:0]       bx_q, bx_d;
  logic [BY_W-1:0]       by_q, by_d;
  logic                  qsel_q, qsel_d;
  logic                  ready_q, ready_d;
  logic [M3_ADDR_W-1:0]  addr_q, addr_d;
  logic [M3_COEFF_W-1:0] data_q, data_d;
  logic                  we_n_q, we_n_d;
  logic                  end_q, end_d;

  logic                         xfer_c;
  logic [M3_RC_W-1:0]           row_c, col_c;
  logic [M3_SHIFT_W-1:0]        shift_c;
  logic signed [M3_WIDE_W-1:0]  wide_c;
  logic signed [M3_WIDE_W-1:0]  shifted_c;
  logic [M3_COEFF_W-1:0]        sat_c;
  logic [M3_ADDR_W-1:0]         waddr_c;

  m3_zigzag_rom u_zz (
    .k_i     (k_q),
    .row_c_o (row_c),
    .col_c_o (col_c)
  );

  // Scaled value with saturation, and raster write address for the current k
  always_comb begin
    xfer_c    = (state_q == S_RUN) && coeff_valid;
    shift_c   = m3_qshift(qsel_q, M3_SUM_W'(row_c) + M3_SUM_W'(col_c));
    wide_c    = {{(M3_WIDE_W - M3_COEFF_W){coeff_data[M3_COEFF_W-1]}}, coeff_data};
    shifted_c = wide_c <<< shift_c;
    if (shifted_c > SAT_HI)      sat_c = 16'h7FFF;
    else if (shifted_c < SAT_LO) sat_c = 16'h8000;
    else                         sat_c = shifted_c[M3_COEFF_W-1:0];
    // {by,row} is by*8+row and {bx,col} is bx*8+col
    waddr_c = BASE_ADDR
            + M3_ADDR_W'(ROW_STRIDE) * M3_ADDR_W'({by_q, row_c})
            + M3_ADDR_W'({bx_q, col_c});
  end

  // Next-state, counter walk and registered-output decode
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    bx_d    = bx_q;
    by_d    = by_q;
    qsel_d  = qsel_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_n_d  = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (m3_start) begin
          qsel_d  = q_sel;
          k_d     = '0;
          bx_d    = '0;
          by_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (xfer_c) begin
          addr_d = waddr_c;
          data_d = sat_c;
          we_n_d = 1'b0;
          if (k_q == K_LAST) begin
            k_d = '0;
            if (bx_q == BX_LAST) begin
              bx_d = '0;
              if (by_q == BY_LAST) begin
                by_d    = '0;
                state_d = S_FLUSH;
              end else begin
                by_d = by_q + 1'b1;
              end
            end else begin
              bx_d = bx_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_RUN);
    end_d   = (state_d == S_DONE);
  end

  // State, counters and output registers
  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      qsel_q  <= 1'b0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      we_n_q  <= 1'b1;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      qsel_q  <= qsel_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_n_q  <= we_n_d;
      end_q   <= end_d;
    end
  end

  assign coeff_ready     = ready_q;
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = data_q;
  assign SRAM_we_n       = we_n_q;
  assign m3_end          = end_q;

endmodule

// File: tb/tb_m3_dequant.sv
// Directed bench for m3_dequant on a 2x1-block image (row stride 16 words).
module tb_m3_dequant;

  localparam int NBX    = 2;
  localparam int NBY    = 1;
  localparam int BASE   = 76800;
  localparam int STRIDE = NBX * 8;
  localparam int NCOEF  = NBX * NBY * 64;

  logic        CLOCK_50_I;
  logic        reset;
  logic        m3_start;
  logic        q_sel;
  logic [15:0] coeff_data;
  logic        coeff_valid;
  logic        coeff_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        m3_end;

  m3_dequant #(
    .BASE_ADDR    (18'd76800),
    .NUM_BLOCKS_X (NBX),
    .NUM_BLOCKS_Y (NBY)
  ) dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .reset           (reset),
    .m3_start        (m3_start),
    .q_sel           (q_sel),
    .coeff_data      (coeff_data),
    .coeff_valid     (coeff_valid),
    .coeff_ready     (coeff_ready),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .m3_end          (m3_end)
  );

  initial CLOCK_50_I = 1'b0;
  always #5 CLOCK_50_I = ~CLOCK_50_I;

  int n_checks = 0;
  int n_fail   = 0;

  int                 zz_r [64];
  int                 zz_c [64];
  logic signed [15:0] coeffs [NCOEF];
  logic [17:0]        wq_addr [$];
  logic [15:0]        wq_data [$];

  int   cyc = 0;
  int   n_xfer = 0;
  int   end_cnt = 0;
  int   last_wr_cyc = 0;
  int   end_cyc = 0;
  logic xfer_prev = 1'b0;
  logic mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int tb_shift(input logic q, input int d);
    if (!q) begin
      if (d == 0) return 3;
      if (d == 1) return 2;
      if (d <= 3) return 3;
      if (d <= 5) return 4;
      if (d <= 7) return 5;
      return 6;
    end
    if (d == 0) return 3;
    if (d <= 3) return 1;
    if (d <= 5) return 2;
    if (d <= 7) return 3;
    if (d <= 9) return 4;
    return 5;
  endfunction

  function automatic logic [15:0] tb_sat(input int v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // Write monitor: records writes, checks write strobe follows each transfer by one cycle
  always @(negedge CLOCK_50_I) begin
    cyc++;
    if (mon_en) check_eq("we_n_after_xfer", 32'(SRAM_we_n), 32'(!xfer_prev));
    if (SRAM_we_n === 1'b0) begin
      wq_addr.push_back(SRAM_address);
      wq_data.push_back(SRAM_write_data);
      last_wr_cyc = cyc;
    end
    if (m3_end === 1'b1) begin
      end_cnt++;
      end_cyc = cyc;
    end
    xfer_prev = coeff_valid & coeff_ready & !reset;
    if (xfer_prev) n_xfer++;
  end

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    n_xfer  = 0;
    end_cnt = 0;
  endtask

  task automatic idle(input int n);
    coeff_valid = 1'b0;
    repeat (n) begin
      @(posedge CLOCK_50_I);
      #1;
    end
  endtask

  task automatic start_image(input logic q);
    q_sel    = q;
    m3_start = 1'b1;
    @(posedge CLOCK_50_I);
    #1;
    m3_start = 1'b0;
    q_sel    = ~q;
    check_eq("ready_after_start", 32'(coeff_ready), 32'd1);
  endtask

  task automatic send(input logic signed [15:0] c);
    logic rdy;
    bit   done;
    done        = 1'b0;
    coeff_data  = c;
    coeff_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLOCK_50_I);
      rdy = coeff_ready;
      @(posedge CLOCK_50_I);
      #1;
      if (rdy) done = 1'b1;
    end
    if (!done) check_eq("send_timeout", 32'd0, 32'd1);
    coeff_valid = 1'b0;
  endtask

  // Called right after the final transfer edge
  task automatic end_checks(input string tag);
    @(negedge CLOCK_50_I);
    check_eq({tag, "_flush_we_n"}, 32'(SRAM_we_n), 32'd0);
    check_eq({tag, "_flush_ready"}, 32'(coeff_ready), 32'd0);
    check_eq({tag, "_flush_end"}, 32'(m3_end), 32'd0);
    @(negedge CLOCK_50_I);
    check_eq({tag, "_done_end"}, 32'(m3_end), 32'd1);
    check_eq({tag, "_done_we_n"}, 32'(SRAM_we_n), 32'd1);
    @(negedge CLOCK_50_I);
    check_eq({tag, "_idle_end"}, 32'(m3_end), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(coeff_ready), 32'd0);
    check_eq({tag, "_end_count"}, 32'(end_cnt), 32'd1);
    check_eq({tag, "_end_after_last_wr"}, 32'(end_cyc), 32'(last_wr_cyc + 1));
    @(posedge CLOCK_50_I);
    #1;
  endtask

  task automatic compare_image(input logic q, input string tag);
    int k, blk, bx, by, r, c, s, v;
    check_eq({tag, "_nwrites"}, 32'(wq_addr.size()), 32'(NCOEF));
    check_eq({tag, "_nxfer"}, 32'(n_xfer), 32'(NCOEF));
    for (int n = 0; n < NCOEF && n < wq_addr.size(); n++) begin
      k   = n % 64;
      blk = n / 64;
      bx  = blk % NBX;
      by  = blk / NBX;
      r   = zz_r[k];
      c   = zz_c[k];
      s   = tb_shift(q, r + c);
      v   = int'(coeffs[n]) * (1 << s);
      check_eq($sformatf("%s_addr%0d", tag, n), 32'(wq_addr[n]),
               32'(BASE + (by * 8 + r) * STRIDE + bx * 8 + c));
      check_eq($sformatf("%s_data%0d", tag, n), 32'(wq_data[n]), 32'(tb_sat(v)));
    end
  endtask

  task automatic fill_coeffs(input int p);
    for (int n = 0; n < NCOEF; n++) coeffs[n] = 16'(((n * 53 + p * 29) % 97) - 48);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, lo, hi;
    // Reference zigzag built by walking anti-diagonals
    idx = 0;
    for (int d = 0; d < 15; d++) begin
      lo = (d > 7) ? d - 7 : 0;
      hi = (d < 7) ? d : 7;
      if (d % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz_r[idx] = r; zz_c[idx] = d - r; idx++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz_r[idx] = r; zz_c[idx] = d - r; idx++;
        end
      end
    end

    reset = 1'b1; m3_start = 1'b0; q_sel = 1'b0; coeff_valid = 1'b0; coeff_data = '0;
    repeat (3) @(posedge CLOCK_50_I);
    #1;
    check_eq("rst_ready", 32'(coeff_ready), 32'd0);
    check_eq("rst_we_n", 32'(SRAM_we_n), 32'd1);
    check_eq("rst_addr", 32'(SRAM_address), 32'd0);
    check_eq("rst_data", 32'(SRAM_write_data), 32'd0);
    check_eq("rst_end", 32'(m3_end), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Valid while idle must be ignored
    coeff_data  = 16'sd123;
    coeff_valid = 1'b1;
    repeat (4) begin @(posedge CLOCK_50_I); #1; end
    coeff_valid = 1'b0;
    check_eq("idle_valid_ready", 32'(coeff_ready), 32'd0);
    check_eq("idle_valid_writes", 32'(wq_addr.size()), 32'd0);

    // Image 1: Q0, random gaps, stray start pulse mid-run with q_sel=1
    clear_log();
    fill_coeffs(1);
    coeffs[0] = 16'sd5; coeffs[1] = -16'sd3; coeffs[2] = 16'sd7;
    start_image(1'b0);
    for (int n = 0; n < NCOEF; n++) begin
      if (n > 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if (n == 40) begin m3_start = 1'b1; q_sel = 1'b1; end
      send(coeffs[n]);
      if (n == 40) begin m3_start = 1'b0; q_sel = 1'b0; end
    end
    end_checks("img1");
    compare_image(1'b0, "img1");
    if (wq_addr.size() == NCOEF) begin
      check_eq("img1_k0_addr", 32'(wq_addr[0]), 32'd76800);
      check_eq("img1_k0_data", 32'(wq_data[0]), 32'd40);
      check_eq("img1_k1_addr", 32'(wq_addr[1]), 32'd76801);
      check_eq("img1_k1_data", 32'(wq_data[1]), 32'h0000FFF4);
      check_eq("img1_k2_addr", 32'(wq_addr[2]), 32'd76816);
      check_eq("img1_k2_data", 32'(wq_data[2]), 32'd28);
      check_eq("img1_blk1_k0_addr", 32'(wq_addr[64]), 32'd76808);
    end

    // Valid after completion must be ignored
    coeff_valid = 1'b1;
    repeat (3) begin @(posedge CLOCK_50_I); #1; end
    coeff_valid = 1'b0;
    check_eq("post_valid_writes", 32'(wq_addr.size()), 32'(NCOEF));

    // Image 2: aborted by reset while k=30 is offered
    clear_log();
    fill_coeffs(2);
    start_image(1'b1);
    for (int n = 0; n < 30; n++) send(coeffs[n]);
    coeff_data  = coeffs[30];
    coeff_valid = 1'b1;
    reset       = 1'b1;
    @(posedge CLOCK_50_I);
    #1;
    reset       = 1'b0;
    coeff_valid = 1'b0;
    check_eq("abort_we_n", 32'(SRAM_we_n), 32'd1);
    check_eq("abort_ready", 32'(coeff_ready), 32'd0);
    check_eq("abort_addr", 32'(SRAM_address), 32'd0);
    check_eq("abort_nwrites", 32'(wq_addr.size()), 32'd30);
    idle(2);
    check_eq("abort_no_end", 32'(end_cnt), 32'd0);

    // Image 3: Q1 restart with saturation cases
    clear_log();
    fill_coeffs(3);
    coeffs[63]  = 16'sd1000;
    coeffs[126] = -16'sd2000;
    coeffs[127] = 16'sd2000;
    start_image(1'b1);
    for (int n = 0; n < NCOEF; n++) begin
      if (n == 100) check_eq("img3_no_early_end", 32'(end_cnt), 32'd0);
      send(coeffs[n]);
    end
    end_checks("img3");
    compare_image(1'b1, "img3");
    if (wq_addr.size() == NCOEF) begin
      check_eq("img3_restart_addr", 32'(wq_addr[0]), 32'd76800);
      check_eq("img3_k63_addr", 32'(wq_addr[63]), 32'd76919);
      check_eq("img3_k63_data", 32'(wq_data[63]), 32'd32000);
      check_eq("img3_blk1_k0_addr", 32'(wq_addr[64]), 32'd76808);
      check_eq("img3_neg_sat_addr", 32'(wq_addr[126]), 32'd76926);
      check_eq("img3_neg_sat_data", 32'(wq_data[126]), 32'h00008000);
      check_eq("img3_pos_sat_addr", 32'(wq_addr[127]), 32'd76927);
      check_eq("img3_pos_sat_data", 32'(wq_data[127]), 32'h00007FFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
